// File: rtl/bp_btb_tagged.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb_tagged
// Description : Tagged branch target buffer with saturating direction
//               counters. IF gets a zero-latency prediction. ID reports the
//               resolved outcome plus the prediction that travelled with the
//               instruction, and the block returns a flush and redirect PC.
//               After reset a sweep clears every valid bit before the table
//               starts predicting.
// Ports       :
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   if_pc_i                 fetch PC
//   if_pred_taken_o         predicted taken
//   if_pred_target_o        predicted target (0 on miss)
//   id_valid_i .. id_pred_target_i  resolved instruction from ID
//   id_flush_o              mispredict, redirect fetch
//   id_flush_pc_o           redirect PC
//   init_busy_o             table clear sweep in progress
//   perf_lookup_o           resolved jumps seen (saturating)
//   perf_mispred_o          flushes issued (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module bp_btb_tagged #(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              if_pred_taken_o,
  output logic [XLEN-1:0]   if_pred_target_o,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic              id_is_jump_i,
  input  logic              id_taken_i,
  input  logic [XLEN-1:0]   id_target_i,
  input  logic              id_pred_taken_i,
  input  logic [XLEN-1:0]   id_pred_target_i,
  output logic              id_flush_o,
  output logic [XLEN-1:0]   id_flush_pc_o,
  output logic              init_busy_o,
  output logic [PERF_W-1:0] perf_lookup_o,
  output logic [PERF_W-1:0] perf_mispred_o
);

  localparam int               c_ENTRIES  = 1 << IDX_W;
  localparam logic [CTR_W-1:0] c_CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] c_CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Table storage. Only the valid bits are ever cleared; the payload fields
  // are meaningless until an allocation sets the matching valid bit.
  logic [c_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag    [c_ENTRIES];
  logic [CTR_W-1:0]     r_ctr    [c_ENTRIES];
  logic [XLEN-1:0]      r_target [c_ENTRIES];

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic                 r_squash;
  logic [PERF_W-1:0]    r_perf_lookup;
  logic [PERF_W-1:0]    r_perf_mispred;

  logic [IDX_W-1:0]     w_if_idx;
  logic [TAG_W-1:0]     w_if_tag;
  logic                 w_if_hit;
  logic [IDX_W-1:0]     w_id_idx;
  logic [TAG_W-1:0]     w_id_tag;
  logic                 w_id_hit;
  logic [CTR_W-1:0]     w_id_ctr;
  logic                 w_busy;
  logic                 w_ev;
  logic                 w_flush;
  logic                 w_upd;

  // Only the index and tag slices of the PCs feed the table lookups.
  logic                 w_unused_pc_bits;
  assign w_unused_pc_bits = ^{if_pc_i, id_pc_i};

  // --------------------------------------------------------------------------
  // Lookups (IF port and ID port)
  // --------------------------------------------------------------------------
  assign w_if_idx = if_pc_i[IDX_W+1:2];
  assign w_if_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  assign w_id_idx = id_pc_i[IDX_W+1:2];
  assign w_id_tag = id_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
  assign w_id_ctr = r_ctr[w_id_idx];

  assign w_busy           = (r_state == ST_INIT);
  assign init_busy_o      = w_busy;
  assign if_pred_taken_o  = w_if_hit && r_ctr[w_if_idx][CTR_W-1] && !w_busy;
  assign if_pred_target_o = w_if_hit ? r_target[w_if_idx] : '0;

  // --------------------------------------------------------------------------
  // Resolution: the slot right after a flush holds a wrong-path instruction.
  // --------------------------------------------------------------------------
  assign w_ev = id_valid_i && !r_squash;

  always_comb begin
    w_flush = 1'b0;
    if (w_ev) begin
      if (id_is_jump_i) begin
        w_flush = (id_pred_taken_i != id_taken_i) ||
                  (id_taken_i && id_pred_taken_i &&
                   (id_pred_target_i != id_target_i));
      end else begin
        w_flush = id_pred_taken_i;
      end
    end
  end

  assign id_flush_o    = w_flush;
  assign id_flush_pc_o = (id_is_jump_i && id_taken_i) ? id_target_i
                                                      : id_pc_i + XLEN'(4);
  assign w_upd         = w_ev && !w_busy;

  // --------------------------------------------------------------------------
  // Init sweep FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_INIT: begin
        w_ptr_nxt = r_ptr + IDX_W'(1);
        if (r_ptr == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Table write. Sweep and update never overlap because updates wait for RUN.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      if (w_busy) begin
        r_valid[r_ptr] <= 1'b0;
      end else if (w_upd) begin
        if (id_is_jump_i) begin
          if (id_taken_i) begin
            // Hit strengthens; miss (re)allocates over whatever was there.
            r_valid[w_id_idx]  <= 1'b1;
            r_tag[w_id_idx]    <= w_id_tag;
            r_target[w_id_idx] <= id_target_i;
            if (!w_id_hit) begin
              r_ctr[w_id_idx] <= c_CTR_WEAK;
            end else if (w_id_ctr != c_CTR_MAX) begin
              r_ctr[w_id_idx] <= w_id_ctr + CTR_W'(1);
            end
          end else if (w_id_hit && (w_id_ctr != '0)) begin
            r_ctr[w_id_idx] <= w_id_ctr - CTR_W'(1);
          end
        end else if (w_id_hit) begin
          // A non-jump matching an entry means an alias: evict it.
          r_valid[w_id_idx] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Squash flag and saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_squash       <= 1'b0;
      r_perf_lookup  <= '0;
      r_perf_mispred <= '0;
    end else begin
      r_squash <= w_flush;
      if (w_ev && id_is_jump_i && (r_perf_lookup != '1)) begin
        r_perf_lookup <= r_perf_lookup + PERF_W'(1);
      end
      if (w_flush && (r_perf_mispred != '1)) begin
        r_perf_mispred <= r_perf_mispred + PERF_W'(1);
      end
    end
  end

  assign perf_lookup_o  = r_perf_lookup;
  assign perf_mispred_o = r_perf_mispred;

endmodule
`default_nettype wire

// File: tb/tb_bp_btb_tagged.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_btb_tagged
// Description : Self-checking bench for bp_btb_tagged. A table-level model of
//               the predictor tracks entries, squash state, sweep length and
//               performance counts; scenario tasks compare the DUT to it and
//               to hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_btb_tagged;

  localparam int XLEN     = 32;
  localparam int IDX_W    = 6;
  localparam int TAG_W    = 8;
  localparam int CTR_W    = 2;
  localparam int PERF_W   = 32;
  localparam int ENTRIES  = 1 << IDX_W;
  localparam int CTR_HALF = 1 << (CTR_W - 1);
  localparam int CTR_TOP  = (1 << CTR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [XLEN-1:0]   if_pc = '0;
  logic              if_pred_taken;
  logic [XLEN-1:0]   if_pred_target;
  logic              id_valid = 1'b0;
  logic [XLEN-1:0]   id_pc = '0;
  logic              id_is_jump = 1'b0;
  logic              id_taken = 1'b0;
  logic [XLEN-1:0]   id_target = '0;
  logic              id_pred_taken = 1'b0;
  logic [XLEN-1:0]   id_pred_target = '0;
  logic              id_flush;
  logic [XLEN-1:0]   id_flush_pc;
  logic              init_busy;
  logic [PERF_W-1:0] perf_lookup;
  logic [PERF_W-1:0] perf_mispred;

  int n_total = 0;
  int n_pass  = 0;

  bp_btb_tagged #(
    .XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_W(CTR_W), .PERF_W(PERF_W)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .if_pc_i          (if_pc),
    .if_pred_taken_o  (if_pred_taken),
    .if_pred_target_o (if_pred_target),
    .id_valid_i       (id_valid),
    .id_pc_i          (id_pc),
    .id_is_jump_i     (id_is_jump),
    .id_taken_i       (id_taken),
    .id_target_i      (id_target),
    .id_pred_taken_i  (id_pred_taken),
    .id_pred_target_i (id_pred_target),
    .id_flush_o       (id_flush),
    .id_flush_pc_o    (id_flush_pc),
    .init_busy_o      (init_busy),
    .perf_lookup_o    (perf_lookup),
    .perf_mispred_o   (perf_mispred)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: an array of entries plus bookkeeping
  // --------------------------------------------------------------------------
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_squash;
  int          m_busy_left;
  longint      m_lookup;
  longint      m_mispred;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> (2 + IDX_W)) % (1 << TAG_W);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_HALF) && (m_busy_left == 0);
  endfunction

  function automatic logic [31:0] m_pred_target(logic [31:0] pc);
    return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'h0;
  endfunction

  function automatic bit m_flush();
    if (!(id_valid && !m_squash)) return 1'b0;
    if (id_is_jump)
      return (id_pred_taken != id_taken) ||
             (id_taken && id_pred_taken && (id_pred_target != id_target));
    return id_pred_taken;
  endfunction

  function automatic logic [31:0] m_flush_pc();
    return (id_is_jump && id_taken) ? id_target : id_pc + 32'd4;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_commit();
    bit f;
    bit ev;
    int i;
    if (!rst_n) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      m_busy_left = ENTRIES;
      m_squash    = 1'b0;
      m_lookup    = 0;
      m_mispred   = 0;
    end else begin
      f  = m_flush();
      ev = id_valid && !m_squash;
      i  = idx_of(id_pc);
      if (ev && id_is_jump && m_lookup < 64'hFFFF_FFFF) m_lookup++;
      if (f && m_mispred < 64'hFFFF_FFFF) m_mispred++;
      if (ev && m_busy_left == 0) begin
        if (id_is_jump && id_taken) begin
          if (m_hit(id_pc)) begin
            m_ctr[i] = (m_ctr[i] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[i] + 1;
          end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(id_pc);
            m_ctr[i]   = CTR_HALF;
          end
          m_tgt[i] = id_target;
        end else if (id_is_jump && m_hit(id_pc)) begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (!id_is_jump && m_hit(id_pc)) begin
          m_valid[i] = 1'b0;
        end
      end
      if (m_busy_left > 0) m_busy_left--;
      m_squash = f;
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic j,
                          input logic t, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
    id_valid = v; id_pc = pc; id_is_jump = j; id_taken = t;
    id_target = tgt; id_pred_taken = pt; id_pred_target = ptgt;
  endtask

  task automatic idle();
    drive_id(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] pool_pc();
    return 32'h8000_0000 | ($urandom_range(1, 0) << (2 + IDX_W)) |
           ($urandom_range(19, 16) << 2);
  endfunction

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_total++;
    if (init_busy !== 1'b1 || perf_lookup !== '0 || perf_mispred !== '0) begin
      $display("FAIL reset_state: busy=%b lookup=%0d mispred=%0d, want busy=1 lookup=0 mispred=0",
               init_busy, perf_lookup, perf_mispred);
    end else n_pass++;
    // Random ID traffic during the sweep must be counted but never written.
    cyc = 0;
    while (init_busy === 1'b1 && cyc < 100) begin
      if_pc = pool_pc();
      drive_id($urandom_range(1, 0), pool_pc(), 1'b1, $urandom_range(1, 0),
               pool_pc(), $urandom_range(1, 0), pool_pc());
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0) begin
        $display("FAIL init_pred_taken: cycle %0d got %b want 0", cyc, if_pred_taken);
      end else n_pass++;
      cyc++;
      tick();
    end
    n_total++;
    if (cyc !== ENTRIES) begin
      $display("FAIL init_length: busy for %0d cycles, want %0d", cyc, ENTRIES);
    end else n_pass++;
    idle();
    #1;
    n_total++;
    if (perf_lookup !== m_lookup[31:0] || perf_mispred !== m_mispred[31:0]) begin
      $display("FAIL init_perf: lookup=%0d mispred=%0d want %0d %0d",
               perf_lookup, perf_mispred, m_lookup, m_mispred);
    end else n_pass++;
    tick();
  endtask

  task automatic test_alloc();
    idle();
    tick();
    drive_id(1'b1, 32'h8000_0040, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
    #1;
    n_total++;
    if (id_flush !== 1'b1 || id_flush_pc !== 32'h8000_0100) begin
      $display("FAIL alloc_flush: flush=%b pc=%h want 1 80000100", id_flush, id_flush_pc);
    end else n_pass++;
    tick();
    idle();
    if_pc = 32'h8000_0040;
    #1;
    n_total++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h8000_0100) begin
      $display("FAIL alloc_predict: taken=%b tgt=%h want 1 80000100",
               if_pred_taken, if_pred_target);
    end else n_pass++;
    tick();
  endtask

  task automatic test_not_taken();
    if_pc = 32'h8000_0040;
    drive_id(1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0100);
    #1;
    n_total++;
    if (id_flush !== 1'b1 || id_flush_pc !== 32'h8000_0044) begin
      $display("FAIL nt_flush: flush=%b pc=%h want 1 80000044", id_flush, id_flush_pc);
    end else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h8000_0100) begin
      $display("FAIL nt_weakened: taken=%b tgt=%h want 0 80000100",
               if_pred_taken, if_pred_target);
    end else n_pass++;
    tick();
    drive_id(1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_total++;
    if (id_flush !== 1'b0) begin
      $display("FAIL nt_no_flush: flush=%b want 0", id_flush);
    end else n_pass++;
    tick();
    tick();  // third not-taken: counter must stay at zero, not wrap
    idle();
    #1;
    n_total++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h8000_0100) begin
      $display("FAIL nt_floor: taken=%b tgt=%h want 0 80000100",
               if_pred_taken, if_pred_target);
    end else n_pass++;
    drive_id(1'b1, 32'h8000_0040, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    n_total++;
    if (if_pred_taken !== 1'b0) begin
      $display("FAIL ctr_sat_low: taken=%b want 0 (counter 1)", if_pred_taken);
    end else n_pass++;
    tick();
  endtask

  task automatic test_alias();
    drive_id(1'b1, 32'h8000_0040, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
    tick();
    tick();  // counter 1 -> 2, weakly taken again
    idle();
    tick();
    if_pc = 32'h8000_4040;
    #1;
    n_total++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
      $display("FAIL alias_miss: taken=%b tgt=%h want 0 0", if_pred_taken, if_pred_target);
    end else n_pass++;
    drive_id(1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0100);
    #1;
    n_total++;
    if (id_flush !== 1'b1 || id_flush_pc !== 32'h8000_0044) begin
      $display("FAIL alias_flush: flush=%b pc=%h want 1 80000044", id_flush, id_flush_pc);
    end else n_pass++;
    tick();
    idle();
    if_pc = 32'h8000_0040;
    #1;
    n_total++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
      $display("FAIL alias_evict: taken=%b tgt=%h want 0 0", if_pred_taken, if_pred_target);
    end else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    longint base_l;
    longint base_m;
    idle();
    tick();
    base_l = m_lookup;
    base_m = m_mispred;
    drive_id(1'b1, 32'h8000_0080, 1'b1, 1'b1, 32'h8000_0300, 1'b0, 32'h0);
    tick();
    drive_id(1'b1, 32'h8000_0200, 1'b1, 1'b1, 32'h8000_0400, 1'b0, 32'h0);
    #1;
    n_total++;
    if (id_flush !== 1'b0) begin
      $display("FAIL squash_flush: flush=%b want 0", id_flush);
    end else n_pass++;
    tick();
    idle();
    if_pc = 32'h8000_0200;
    #1;
    n_total++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
      $display("FAIL squash_no_write: taken=%b tgt=%h want 0 0", if_pred_taken, if_pred_target);
    end else n_pass++;
    n_total++;
    if (perf_mispred !== PERF_W'(base_m + 1) || perf_lookup !== PERF_W'(base_l + 1)) begin
      $display("FAIL squash_perf: mispred=%0d lookup=%0d want %0d %0d",
               perf_mispred, perf_lookup, base_m + 1, base_l + 1);
    end else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] tgts[3];
    int errs;
    tgts[0] = 32'h8000_0100; tgts[1] = 32'h8000_0200; tgts[2] = 32'h9000_0000;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      if_pc = pool_pc();
      id_valid   = ($urandom_range(9, 0) != 0);
      id_pc      = pool_pc();
      id_is_jump = ($urandom_range(3, 0) != 0);
      id_taken   = $urandom_range(1, 0);
      id_target  = tgts[$urandom_range(2, 0)];
      if ($urandom_range(1, 0) == 1) begin
        id_pred_taken  = m_pred_taken(id_pc);
        id_pred_target = m_pred_target(id_pc);
      end else begin
        id_pred_taken  = $urandom_range(1, 0);
        id_pred_target = tgts[$urandom_range(2, 0)];
      end
      #1;
      n_total++;
      if (if_pred_taken !== m_pred_taken(if_pc) || if_pred_target !== m_pred_target(if_pc) ||
          id_flush !== m_flush() || id_flush_pc !== m_flush_pc() || init_busy !== 1'b0 ||
          perf_lookup !== m_lookup[31:0] || perf_mispred !== m_mispred[31:0]) begin
        if (errs < 10)
          $display("FAIL rand_cycle%0d: if=%h pt=%b tgt=%h fl=%b fpc=%h lk=%0d mp=%0d want pt=%b tgt=%h fl=%b fpc=%h lk=%0d mp=%0d",
                   c, if_pc, if_pred_taken, if_pred_target, id_flush, id_flush_pc,
                   perf_lookup, perf_mispred, m_pred_taken(if_pc), m_pred_target(if_pc),
                   m_flush(), m_flush_pc(), m_lookup, m_mispred);
        errs++;
      end else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [31:0] pc;
    idle();
    tick();
    for (int k = 0; k < 10; k++) begin
      pc = 32'h8000_0000 | (32'(k) << 2) | (32'h3 << (2 + IDX_W));
      drive_id(1'b1, pc, 1'b1, 1'b1, 32'hA000_0000 + 32'(k * 16), 1'b0, 32'h0);
      tick();
      idle();
      tick();
    end
    if_pc = 32'h8000_0300 | (32'd5 << 2);
    #1;
    n_total++;
    if (if_pred_target !== 32'hA000_0050) begin
      $display("FAIL pre_reset_hit: tgt=%h want a0000050", if_pred_target);
    end else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_total++;
    if (perf_lookup !== '0 || perf_mispred !== '0 || init_busy !== 1'b1 || if_pred_taken !== 1'b0) begin
      $display("FAIL midrun_reset: lookup=%0d mispred=%0d busy=%b pt=%b want 0 0 1 0",
               perf_lookup, perf_mispred, init_busy, if_pred_taken);
    end else n_pass++;
    cyc = 0;
    while (init_busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    n_total++;
    if (cyc !== ENTRIES) begin
      $display("FAIL resweep_length: busy for %0d cycles, want %0d", cyc, ENTRIES);
    end else n_pass++;
    for (int k = 0; k < 10; k++) begin
      if_pc = 32'h8000_0000 | (32'(k) << 2) | (32'h3 << (2 + IDX_W));
      #1;
      n_total++;
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
        $display("FAIL resweep_cleared%0d: taken=%b tgt=%h want 0 0", k,
                 if_pred_taken, if_pred_target);
      end else n_pass++;
    end
  endtask

  initial begin
    m_squash = 1'b0; m_busy_left = ENTRIES; m_lookup = 0; m_mispred = 0;
    foreach (m_valid[k]) begin
      m_valid[k] = 1'b0; m_tag[k] = 0; m_ctr[k] = 0; m_tgt[k] = 32'h0;
    end
    #1;
    test_reset();
    test_alloc();
    test_not_taken();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
